// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle main controller.
//   - state_t      : 4-bit controller state encoding
//   - OP_*         : instruction opcode constants (IR[15:12])
//   - ALUOP_*      : 2-bit aluop values for the ALU control decoder
//   - SRCB_*       : ALU B-operand select values
//   - moore_t      : bundle of the outputs that depend on the state only
//   - decode_target: next state chosen in DECODE (FETCH means unmapped opcode)
//   - moore_decode : state-only output decode
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_C   = 4'd6,
        S_WB_C     = 4'd7,
        S_EXEC_D   = 4'd8,
        S_WB_D     = 4'd9,
        S_JUMP     = 4'd10,
        S_BRZ_CMP  = 4'd11,
        S_BRZ_TGT  = 4'd12
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_JUMP  = 4'b0010;
    localparam logic [3:0] OP_BRZ   = 4'b0100;
    localparam logic [3:0] OP_TYPEC = 4'b1000;
    // Type-D occupies the whole 11xx quadrant.
    localparam logic [1:0] OP_TYPED_HI = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_TYPEC = 2'b10;
    localparam logic [1:0] ALUOP_TYPED = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_ZERO = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] aluop;
    } moore_t;

    // Dispatch target out of DECODE. Unmapped opcodes return S_FETCH,
    // which the controller also uses as its illegal-opcode indication.
    function automatic state_t decode_target(input logic [3:0] op);
        state_t t;
        if (op[3:2] == OP_TYPED_HI) begin
            t = S_EXEC_D;
        end else begin
            case (op)
                OP_LOAD:  t = S_MEM_ADDR;
                OP_STORE: t = S_MEM_ADDR;
                OP_JUMP:  t = S_JUMP;
                OP_BRZ:   t = S_BRZ_CMP;
                OP_TYPEC: t = S_EXEC_C;
                default:  t = S_FETCH;
            endcase
        end
        return t;
    endfunction

    // Outputs that are a pure function of the state.
    function automatic moore_t moore_decode(input state_t s);
        moore_t m;
        m = '0;
        case (s)
            S_FETCH: begin
                m.mem_read = 1'b1;
            end
            S_MEM_ADDR: begin
                m.alu_src_a = 1'b1;
                m.alu_src_b = SRCB_IMM;
                m.aluop     = ALUOP_ADD;
            end
            S_MEM_RD: begin
                m.mem_read = 1'b1;
                m.iord     = 1'b1;
            end
            S_MEM_WB: begin
                m.reg_write  = 1'b1;
                m.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                m.mem_write = 1'b1;
                m.iord      = 1'b1;
            end
            S_EXEC_C: begin
                m.alu_src_a = 1'b1;
                m.alu_src_b = SRCB_REG;
                m.aluop     = ALUOP_TYPEC;
            end
            S_WB_C: begin
                m.alu_src_a = 1'b1;
                m.alu_src_b = SRCB_REG;
                m.aluop     = ALUOP_TYPEC;
                m.reg_write = 1'b1;
            end
            S_EXEC_D: begin
                m.alu_src_a = 1'b1;
                m.alu_src_b = SRCB_IMM;
                m.aluop     = ALUOP_TYPED;
            end
            S_WB_D: begin
                m.alu_src_a = 1'b1;
                m.alu_src_b = SRCB_IMM;
                m.aluop     = ALUOP_TYPED;
                m.reg_write = 1'b1;
            end
            S_JUMP: begin
                m.alu_src_b = SRCB_IMM;
                m.aluop     = ALUOP_ADD;
                m.pc_write  = 1'b1;
            end
            S_BRZ_CMP: begin
                m.alu_src_a = 1'b1;
                m.alu_src_b = SRCB_ZERO;
                m.aluop     = ALUOP_SUB;
            end
            S_BRZ_TGT: begin
                m.alu_src_b = SRCB_IMM;
                m.aluop     = ALUOP_ADD;
                m.pc_write  = 1'b1;
            end
            default: begin
                m = '0;
            end
        endcase
        return m;
    endfunction

endpackage

// File: rtl/main_controller.sv
// Multi-cycle main control FSM: fetch/decode/execute/writeback sequencing
// with a mem_ready handshake and a wait-state watchdog.
// Parameter:
//   TIMEOUT     max cycles a memory access may wait before bus_error (1..255)
// Ports:
//   clk, rst_n  rising-edge clock, asynchronous active-low reset
//   opcode      IR[15:12], sampled in DECODE
//   zero        ALU zero flag, sampled in BRZ_CMP
//   mem_ready   memory completes the current access this cycle
//   pc_write, pc_inc, iord, mem_read, mem_write, ir_write, reg_write,
//   mem_to_reg, alu_src_a, alu_src_b, aluop   datapath controls
//   instr_done  pulse on the last cycle of a completed instruction
//   illegal_op  pulse in DECODE for an unmapped opcode
//   bus_error   pulse when a memory access times out
module main_controller
    import ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_inc,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] aluop,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       bus_error
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state_r;
    state_t     state_next_s;
    logic [7:0] wait_cnt_r;
    logic [7:0] wait_cnt_next_s;
    logic       zero_q_r;
    logic       is_store_r;
    logic       active_r;
    moore_t     moore_r;

    logic       mem_state_s;
    logic       timeout_s;
    logic       illegal_s;
    logic       done_s;
    logic       fetch_ack_s;

    // active_r is low during reset and for the first cycle after release, so
    // every output is 0 until the first clock edge and the FSM holds FETCH.
    // Watchdog qualifiers: a request is pending in FETCH, MEM_RD and MEM_WR.
    always_comb begin
        mem_state_s = (state_r == S_FETCH) || (state_r == S_MEM_RD) ||
                      (state_r == S_MEM_WR);
        // mem_ready in the expiry cycle wins over the timeout.
        timeout_s   = active_r && mem_state_s && !mem_ready &&
                      (wait_cnt_r == WAIT_LAST);
        illegal_s   = active_r && (state_r == S_DECODE) &&
                      (decode_target(opcode) == S_FETCH);
        fetch_ack_s = active_r && (state_r == S_FETCH) && mem_ready;
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        if (!active_r) begin
            state_next_s = state_r;
        end else if (timeout_s) begin
            state_next_s = S_FETCH;
        end else begin
            case (state_r)
                S_FETCH:    state_next_s = mem_ready ? S_DECODE : S_FETCH;
                S_DECODE:   state_next_s = decode_target(opcode);
                S_MEM_ADDR: state_next_s = is_store_r ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   state_next_s = mem_ready ? S_MEM_WB : S_MEM_RD;
                S_MEM_WB:   state_next_s = S_FETCH;
                S_MEM_WR:   state_next_s = mem_ready ? S_FETCH : S_MEM_WR;
                S_EXEC_C:   state_next_s = S_WB_C;
                S_WB_C:     state_next_s = S_FETCH;
                S_EXEC_D:   state_next_s = S_WB_D;
                S_WB_D:     state_next_s = S_FETCH;
                S_JUMP:     state_next_s = S_FETCH;
                S_BRZ_CMP:  state_next_s = zero ? S_BRZ_TGT : S_FETCH;
                S_BRZ_TGT:  state_next_s = S_FETCH;
                default:    state_next_s = S_FETCH;
            endcase
        end
    end

    // Completion pulse; depends on mem_ready/zero in the states that wait on them.
    always_comb begin
        done_s = 1'b0;
        if (!active_r) begin
            done_s = 1'b0;
        end else begin
            case (state_r)
                S_MEM_WB:  done_s = 1'b1;
                S_WB_C:    done_s = 1'b1;
                S_WB_D:    done_s = 1'b1;
                S_JUMP:    done_s = 1'b1;
                S_MEM_WR:  done_s = mem_ready;
                S_BRZ_CMP: done_s = !zero;
                // zero_q_r is always 1 here: BRZ_TGT is only reached on zero=1.
                S_BRZ_TGT: done_s = zero_q_r;
                default:   done_s = 1'b0;
            endcase
        end
    end

    // Wait counter next value: counts only while staying in a memory state
    // without mem_ready; any state change, mem_ready or expiry clears it.
    always_comb begin
        wait_cnt_next_s = 8'd0;
        if (active_r && mem_state_s && !mem_ready && !timeout_s &&
            (state_next_s == state_r)) begin
            wait_cnt_next_s = wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_next_s = 8'd0;
        end
    end

    // State, watchdog and captured-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_FETCH;
            wait_cnt_r <= 8'd0;
            zero_q_r   <= 1'b0;
            is_store_r <= 1'b0;
            active_r   <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
            active_r   <= 1'b1;
            if (active_r && (state_r == S_BRZ_CMP)) begin
                zero_q_r <= zero;
            end else begin
                zero_q_r <= zero_q_r;
            end
            if (active_r && (state_r == S_DECODE)) begin
                is_store_r <= (opcode == OP_STORE);
            end else begin
                is_store_r <= is_store_r;
            end
        end
    end

    // Registered state-only outputs, loaded with the decode of the state being
    // entered so they line up with state_r and clear asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            moore_r <= '0;
        end else begin
            moore_r <= moore_decode(state_next_s);
        end
    end

    assign pc_write   = moore_r.pc_write;
    assign iord       = moore_r.iord;
    assign mem_read   = moore_r.mem_read;
    assign mem_write  = moore_r.mem_write;
    assign reg_write  = moore_r.reg_write;
    assign mem_to_reg = moore_r.mem_to_reg;
    assign alu_src_a  = moore_r.alu_src_a;
    assign alu_src_b  = moore_r.alu_src_b;
    assign aluop      = moore_r.aluop;
    assign ir_write   = fetch_ack_s;
    assign pc_inc     = fetch_ack_s;
    assign instr_done = done_s;
    assign illegal_op = illegal_s;
    assign bus_error  = timeout_s;

endmodule

// File: tb/tb_main_controller.sv
// Self-checking bench for main_controller: directed scenarios with literal
// expectations, then randomized opcode/mem_ready/zero/reset stimulus checked
// every cycle against an instruction-step model.
module tb_main_controller;

    localparam int TO = 4;

    localparam int K_LOAD  = 0;
    localparam int K_STORE = 1;
    localparam int K_JUMP  = 2;
    localparam int K_BRZ   = 3;
    localparam int K_C     = 4;
    localparam int K_D     = 5;
    localparam int K_ILL   = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_inc, iord, mem_read, mem_write, ir_write;
    logic       reg_write, mem_to_reg, alu_src_a, instr_done, illegal_op, bus_error;
    logic [1:0] alu_src_b, aluop;

    int n_checks = 0;
    int n_errors = 0;

    // model: step within the instruction (0 fetch, 1 decode, 2.. later steps)
    int step = 0;
    int kind = K_ILL;
    int waits = 0;
    bit started = 1'b0;

    main_controller #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_inc(pc_inc),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop),
        .instr_done(instr_done), .illegal_op(illegal_op), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    function automatic int classify(input logic [3:0] op);
        if (op == 4'd0) return K_LOAD;
        if (op == 4'd1) return K_STORE;
        if (op == 4'd2) return K_JUMP;
        if (op == 4'd4) return K_BRZ;
        if (op == 4'd8) return K_C;
        if (op[3:2] == 2'b11) return K_D;
        return K_ILL;
    endfunction

    function automatic bit in_mem();
        return (step == 0) || (step == 3 && (kind == K_LOAD || kind == K_STORE));
    endfunction

    function automatic bit expired();
        return in_mem() && !mem_ready && (waits == TO - 1);
    endfunction

    // Expected {pc_write,pc_inc,iord,mem_read,mem_write,ir_write,reg_write,
    //           mem_to_reg,alu_src_a,alu_src_b,aluop,instr_done,illegal_op,bus_error}
    function automatic logic [15:0] expected();
        logic pw, pi, io, mr, mw, irw, rw, m2r, sa, id, il, be;
        logic [1:0] sb, ao;
        {pw, pi, io, mr, mw, irw, rw, m2r, sa, id, il, be} = 12'd0;
        sb = 2'd0;
        ao = 2'd0;
        if (started && rst_n) begin
            be = expired();
            if (step == 0) begin
                mr = 1'b1;
                irw = mem_ready;
                pi = mem_ready;
            end else if (step == 1) begin
                il = (classify(opcode) == K_ILL);
            end else if (step == 2) begin
                if (kind == K_LOAD || kind == K_STORE) begin
                    sa = 1'b1; sb = 2'd1; ao = 2'd0;
                end else if (kind == K_JUMP) begin
                    sb = 2'd1; pw = 1'b1; id = 1'b1;
                end else if (kind == K_BRZ) begin
                    sa = 1'b1; sb = 2'd2; ao = 2'd1; id = !zero;
                end else if (kind == K_C) begin
                    sa = 1'b1; sb = 2'd0; ao = 2'd2;
                end else begin
                    sa = 1'b1; sb = 2'd1; ao = 2'd3;
                end
            end else if (step == 3) begin
                if (kind == K_LOAD) begin
                    mr = 1'b1; io = 1'b1;
                end else if (kind == K_STORE) begin
                    mw = 1'b1; io = 1'b1; id = mem_ready;
                end else if (kind == K_BRZ) begin
                    sb = 2'd1; pw = 1'b1; id = 1'b1;
                end else if (kind == K_C) begin
                    sa = 1'b1; ao = 2'd2; rw = 1'b1; id = 1'b1;
                end else begin
                    sa = 1'b1; sb = 2'd1; ao = 2'd3; rw = 1'b1; id = 1'b1;
                end
            end else begin
                rw = 1'b1; m2r = 1'b1; id = 1'b1;
            end
        end
        return {pw, pi, io, mr, mw, irw, rw, m2r, sa, sb, ao, id, il, be};
    endfunction

    // Advance the model with the inputs present at the clock edge.
    task automatic model_update();
        int nxt;
        bit to;
        if (!rst_n) begin
            started = 1'b0; step = 0; waits = 0;
        end else if (!started) begin
            started = 1'b1;
        end else begin
            to = expired();
            nxt = 0;
            if (step == 0) begin
                nxt = mem_ready ? 1 : 0;
            end else if (step == 1) begin
                kind = classify(opcode);
                nxt = (kind == K_ILL) ? 0 : 2;
            end else if (step == 2) begin
                if (kind == K_JUMP) nxt = 0;
                else if (kind == K_BRZ) nxt = zero ? 3 : 0;
                else nxt = 3;
            end else if (step == 3 && (kind == K_LOAD || kind == K_STORE)) begin
                if (mem_ready) nxt = (kind == K_LOAD) ? 4 : 0;
                else nxt = to ? 0 : 3;
            end else begin
                nxt = 0;
            end
            if (in_mem() && !mem_ready && !to && nxt == step) waits = waits + 1;
            else waits = 0;
            step = nxt;
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        chk("outputs", {pc_write, pc_inc, iord, mem_read, mem_write, ir_write,
                        reg_write, mem_to_reg, alu_src_a, alu_src_b, aluop,
                        instr_done, illegal_op, bus_error}, expected());
        chk("rd_wr_excl", 16'(mem_read & mem_write), 16'd0);
        chk("pcw_pci_excl", 16'(pc_write & pc_inc), 16'd0);
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cyc(input logic [3:0] op, input logic rdy, input logic z);
        opcode = op;
        mem_ready = rdy;
        zero = z;
        sample();
    endtask

    initial begin
        int p;
        // reset
        repeat (2) begin
            cyc(4'd8, 1'b1, 1'b0);
            advance();
        end
        rst_n = 1'b1;
        cyc(4'd8, 1'b1, 1'b0);
        chk("first_cycle_idle", 16'(mem_read), 16'd0);
        advance();

        // 1: Type-C, 4 cycles
        cyc(4'd8, 1'b1, 1'b0);
        chk("t1_fetch_rd", 16'(mem_read), 16'd1);
        chk("t1_irw", 16'(ir_write), 16'd1);
        advance();
        cyc(4'd8, 1'b1, 1'b0); advance();
        cyc(4'd8, 1'b1, 1'b0);
        chk("t1_aluop", 16'(aluop), 16'd2);
        advance();
        cyc(4'd8, 1'b1, 1'b0);
        chk("t1_wb", 16'({reg_write, instr_done}), 16'd3);
        advance();

        // 2: LOAD with 3 wait cycles in MEM_RD
        cyc(4'd0, 1'b1, 1'b0); advance();
        cyc(4'd0, 1'b1, 1'b0); advance();
        cyc(4'd0, 1'b1, 1'b0);
        chk("t2_addr_srcb", 16'(alu_src_b), 16'd1);
        advance();
        for (int i = 0; i < 4; i++) begin
            cyc(4'd0, (i == 3), 1'b0);
            chk("t2_mem_rd", 16'({mem_read, iord}), 16'd3);
            advance();
        end
        cyc(4'd0, 1'b1, 1'b0);
        chk("t2_wb", 16'({reg_write, mem_to_reg}), 16'd3);
        advance();

        // 3: BRZ taken then not taken
        cyc(4'd4, 1'b1, 1'b1); advance();
        cyc(4'd4, 1'b1, 1'b1); advance();
        cyc(4'd4, 1'b1, 1'b1);
        chk("t3_cmp_aluop", 16'(aluop), 16'd1);
        advance();
        cyc(4'd4, 1'b1, 1'b0);
        chk("t3_tgt", 16'({pc_write, aluop}), 16'b100);
        advance();
        cyc(4'd4, 1'b1, 1'b0); advance();
        cyc(4'd4, 1'b1, 1'b0); advance();
        cyc(4'd4, 1'b1, 1'b0);
        chk("t3_nt_done", 16'({instr_done, pc_write}), 16'b10);
        advance();

        // 4: FETCH stall until timeout
        for (int i = 0; i < 4; i++) begin
            cyc(4'd8, 1'b0, 1'b0);
            chk("t4_bus_error", 16'(bus_error), 16'(i == 3));
            chk("t4_no_irw", 16'(ir_write), 16'd0);
            advance();
        end
        cyc(4'd8, 1'b0, 1'b0);
        chk("t4_refetch", 16'({mem_read, bus_error}), 16'b10);
        advance();

        // 5: illegal opcode
        cyc(4'd7, 1'b1, 1'b0); advance();
        cyc(4'd7, 1'b1, 1'b0);
        chk("t5_illegal", 16'(illegal_op), 16'd1);
        advance();
        cyc(4'd1, 1'b1, 1'b0);
        chk("t5_after", 16'({mem_read, reg_write, pc_write}), 16'b100);
        advance();

        // 6: async reset in MEM_WR
        cyc(4'd1, 1'b1, 1'b0); advance();
        cyc(4'd1, 1'b1, 1'b0); advance();
        cyc(4'd1, 1'b0, 1'b0);
        chk("t6_mem_wr", 16'(mem_write), 16'd1);
        #2 rst_n = 1'b0;
        #1 chk("t6_async_drop", 16'(mem_write), 16'd0);
        started = 1'b0; step = 0; waits = 0;
        @(posedge clk); #1;
        cyc(4'd8, 1'b1, 1'b0); advance();
        rst_n = 1'b1;
        cyc(4'd8, 1'b1, 1'b0); advance();
        cyc(4'd8, 1'b1, 1'b0);
        chk("t6_fetch", 16'(mem_read), 16'd1);
        advance();

        // randomized
        p = 80;
        for (int n = 0; n < 3000; n++) begin
            if (n % 64 == 0) begin
                case ($urandom_range(0, 2))
                    0: p = 85;
                    1: p = 35;
                    default: p = 5;
                endcase
            end
            rst_n = ($urandom_range(0, 399) != 0);
            cyc(4'($urandom_range(0, 15)), ($urandom_range(0, 99) < p),
                1'($urandom_range(0, 1)));
            advance();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
